// File: rtl/inv_round_mixer_pkg.sv
// Shared AES inverse-round definitions: widths, mixer FSM encoding and
// InvMixColumns coefficients with a GF(2^8) multiply helper.
package inv_round_mixer_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = STATE_W / COL_W;
    localparam int NUM_ROWS = COL_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    // First row of the circulant InvMixColumns matrix; row r is this rotated right by r.
    localparam logic [BYTE_W-1:0] COEF_0E = 8'h0e;
    localparam logic [BYTE_W-1:0] COEF_0B = 8'h0b;
    localparam logic [BYTE_W-1:0] COEF_0D = 8'h0d;
    localparam logic [BYTE_W-1:0] COEF_09 = 8'h09;

    function automatic logic [BYTE_W-1:0] inv_mix_coef(input int k);
        case (k & 3)
            0:       return COEF_0E;
            1:       return COEF_0B;
            2:       return COEF_0D;
            default: return COEF_09;
        endcase
    endfunction

    // Shift-and-add multiply modulo x^8+x^4+x^3+x+1; constant b folds to an XOR network.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] term;
        acc  = '0;
        term = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) acc ^= term;
            term = {term[BYTE_W-2:0], 1'b0} ^ (term[BYTE_W-1] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_round_mixer_mix_col.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module inv_mix_col
    import inv_round_mixer_pkg::*;
(
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] mixed
);

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        mixed = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int j = 0; j < NUM_ROWS; j++) begin
                mixed[COL_W-1-BYTE_W*r -: BYTE_W] ^=
                    gf_mul(col[COL_W-1-BYTE_W*j -: BYTE_W], inv_mix_coef(j - r));
            end
        end
    end

endmodule

// File: rtl/inv_round_mixer.sv
// AddRoundKey + iterative InvMixColumns over COLS_PER_CYCLE columns per cycle.
// Optional feature macro: ARK_LAST_ROUND_BYPASS_EN (adds in_last, skips mixing on the final round).
module inv_round_mixer
    import inv_round_mixer_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [STATE_W-1:0] in_key,
`ifdef ARK_LAST_ROUND_BYPASS_EN
    input  logic               in_last,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

    mix_state_e         state;
    mix_state_e         next_state;
    logic [1:0]         cnt;
    logic [STATE_W-1:0] work_buf;
    logic [STATE_W-1:0] mixed_buf;
    logic               bypass;
    logic               accept;
    logic               last_step;

    logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

`ifdef ARK_LAST_ROUND_BYPASS_EN
    assign bypass = in_last;
`else
    assign bypass = 1'b0;
`endif

    assign accept    = (state == ST_IDLE) && in_valid;
    assign last_step = (state == ST_MIX) && (cnt == LAST_CNT);

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [1:0] col_idx;
        assign col_idx   = cnt + 2'(g);
        assign col_in[g] = work_buf[STATE_W-1-COL_W*int'(col_idx) -: COL_W];

        inv_mix_col u_inv_mix_col (
            .col   (col_in[g]),
            .mixed (col_out[g])
        );
    end

    always_comb begin
        mixed_buf = work_buf;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            mixed_buf[STATE_W-1-COL_W*int'(cnt + 2'(g)) -: COL_W] = col_out[g];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (in_valid)  next_state = bypass ? ST_DONE : ST_MIX;
            ST_MIX:  if (last_step) next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        out_state = work_buf;
    end

    // NOTE: the work buffer is reset because it drives out_state directly and must read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_buf <= '0;
            cnt      <= '0;
        end else if (accept) begin
            work_buf <= in_state ^ in_key;
            cnt      <= '0;
        end else if (state == ST_MIX) begin
            work_buf <= mixed_buf;
            cnt      <= cnt + CNT_STEP;
        end
    end

endmodule

// File: tb/tb_inv_round_mixer.sv
// Self-checking bench: one DUT with COLS_PER_CYCLE=1 (index 0) and one with 4 (index 1),
// compared against a polynomial-arithmetic InvMixColumns model.
module tb_inv_round_mixer;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_state  [2];
    logic [127:0] in_key    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_state [2];
`ifdef ARK_LAST_ROUND_BYPASS_EN
    logic         in_last   [2];
`endif

    int checks;
    int errors;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        inv_round_mixer #(.COLS_PER_CYCLE(g == 0 ? 1 : 4)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_key    (in_key[g]),
`ifdef ARK_LAST_ROUND_BYPASS_EN
            .in_last   (in_last[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] prod;
        prod = 0;
        for (int i = 0; i < 8; i++) if (b[i]) prod ^= (32'(a) << i);
        for (int k = 14; k >= 8; k--) if (prod[k]) prod ^= (32'h11b << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [31:0] inv_mix_ref(input logic [31:0] col);
        logic [7:0] m [4][4];
        logic [7:0] b [4];
        logic [31:0] res;
        m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
              '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        for (int j = 0; j < 4; j++) b[j] = col[31 - 8*j -: 8];
        res = 0;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] s;
            s = 0;
            for (int j = 0; j < 4; j++) s ^= gf_ref(b[j], m[r][j]);
            res[31 - 8*r -: 8] = s;
        end
        return res;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key, input bit last);
        logic [127:0] x;
        logic [127:0] res;
        x = st ^ key;
        if (last) return x;
        for (int c = 0; c < 4; c++) res[127 - 32*c -: 32] = inv_mix_ref(x[127 - 32*c -: 32]);
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int exp_lat(input int idx, input bit last);
        if (last) return 1;
        return (idx == 0) ? 5 : 2;
    endfunction

    // Waits (bounded) for in_ready, then presents one word for exactly one accepting edge.
    task automatic accept_word(input int idx, input logic [127:0] st, input logic [127:0] key, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready[idx]) begin
            errors++;
            $display("FAIL accept_timeout[%0d]: in_ready=%b required 1", idx, in_ready[idx]);
        end
        in_valid[idx] = 1'b1;
        in_state[idx] = st;
        in_key[idx]   = key;
`ifdef ARK_LAST_ROUND_BYPASS_EN
        in_last[idx]  = last;
`endif
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
    endtask

    // Counts periods after the accepting edge until out_valid; optional noise on the input side.
    task automatic wait_out(input int idx, input bit noise, output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid[idx]) break;
            if (noise) begin
                in_valid[idx] = 1'b1;
                in_state[idx] = rand128();
                in_key[idx]   = rand128();
            end
        end
        in_valid[idx] = 1'b0;
        checks++;
        if (!out_valid[idx]) begin
            errors++;
            $display("FAIL out_valid_timeout[%0d]: out_valid never rose within 20 cycles", idx);
        end
    endtask

    task automatic handshake(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0) begin
            errors++;
            $display("FAIL return_idle[%0d]: in_ready=%b out_valid=%b required 1 0",
                     idx, in_ready[idx], out_valid[idx]);
        end
    endtask

    task automatic run_check(input string name, input int idx, input logic [127:0] st,
                             input logic [127:0] key, input bit last, input bit noise,
                             input logic [127:0] expected);
        int lat;
        accept_word(idx, st, key, last);
        wait_out(idx, noise, lat);
        checks++;
        if (out_state[idx] !== expected) begin
            errors++;
            $display("FAIL %s[%0d]: out_state=%h required %h", name, idx, out_state[idx], expected);
        end
        checks++;
        if (lat != exp_lat(idx, last)) begin
            errors++;
            $display("FAIL %s_latency[%0d]: out_valid at cycle %0d required %0d",
                     name, idx, lat, exp_lat(idx, last));
        end
        handshake(idx);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_state[i]  = '0;
            in_key[i]    = '0;
            out_ready[i] = 1'b0;
`ifdef ARK_LAST_ROUND_BYPASS_EN
            in_last[i]   = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid[i] !== 1'b0 || out_state[i] !== '0 || in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state[%0d]: out_valid=%b out_state=%h in_ready=%b required 0 0 1",
                         i, out_valid[i], out_state[i], in_ready[i]);
            end
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] st_a;
        logic [127:0] st_b;
        st_a = {4{32'h8e4da1bc}};
        st_b = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
        run_check("vec_uniform", 0, st_a, '0, 1'b0, 1'b0, {4{32'hdb135345}});
        run_check("vec_columns", 1, st_b, '0, 1'b0, 1'b0,
                  {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345});
        run_check("vec_uniform", 1, st_a, '0, 1'b0, 1'b0, model(st_a, '0, 1'b0));
        run_check("vec_columns", 0, st_b, '0, 1'b0, 1'b0, model(st_b, '0, 1'b0));
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [127:0] st;
            logic [127:0] key;
            st  = rand128();
            key = rand128();
            run_check("random", n % 2, st, key, 1'b0, n[2], model(st, key, 1'b0));
        end
    endtask

    task automatic test_key_cancel();
        for (int i = 0; i < 2; i++) begin
            logic [127:0] st;
            st = rand128();
            run_check("key_cancel", i, st, st, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] expected;
        int lat;
        int bad;
        st       = rand128();
        key      = rand128();
        expected = model(st, key, 1'b0);
        accept_word(0, st, key, 1'b0);
        wait_out(0, 1'b0, lat);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = 1'b1;
            in_state[0] = rand128();
            @(negedge clk);
            if (out_valid[0] !== 1'b1 || out_state[0] !== expected || in_ready[0] !== 1'b0) bad++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, last out_valid=%b in_ready=%b out_state=%h required 1 0 %h",
                     bad, out_valid[0], in_ready[0], out_state[0], expected);
        end
        handshake(0);
    endtask

    task automatic test_reset_mid_mix();
        logic [127:0] st;
        int lat;
        st = rand128();
        accept_word(0, st, '0, 1'b0);
        lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || out_state[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid_mix: out_valid=%b out_state=%h required 0 0", out_valid[0], out_state[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mix_release: in_ready=%b out_valid=%b required 1 0", in_ready[0], out_valid[0]);
        end
        st = rand128();
        run_check("after_reset", 0, st, '0, 1'b0, 1'b0, model(st, '0, 1'b0));
    endtask

`ifdef ARK_LAST_ROUND_BYPASS_EN
    task automatic test_bypass();
        logic [127:0] st;
        logic [127:0] key;
        for (int i = 0; i < 2; i++) begin
            run_check("bypass_vec", i, {4{32'h8e4da1bc}}, '0, 1'b1, 1'b0, {4{32'h8e4da1bc}});
            st  = rand128();
            key = rand128();
            run_check("bypass_rand", i, st, key, 1'b1, 1'b0, st ^ key);
            run_check("not_last", i, st, key, 1'b0, 1'b0, model(st, key, 1'b0));
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_known_vectors();
        test_random();
        test_key_cancel();
        test_backpressure();
        test_reset_mid_mix();
`ifdef ARK_LAST_ROUND_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
